// File: rtl/chad_irq_pkg.sv
// chad_irq_pkg -- shared definitions for the chad_irqctl interrupt controller.
//   NSRC           : number of interrupt sources (fixed at 16)
//   REG_*          : register index decode for io_addr
//   CTRL_*         : bit positions inside the CTRL register
//   irq_state_e    : controller FSM encoding (also exported as a debug port)
//   pick_lowest()  : fixed-priority encoder, index 0 wins
package chad_irq_pkg;

    localparam int NSRC = 16;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int CTRL_GIE_BIT   = 0;  // rw: global interrupt enable
    localparam int CTRL_EOI_BIT   = 1;  // write-only strobe: end of interrupt
    localparam int CTRL_VEC_LSB   = 1;  // read: in-service vector, 4 bits
    localparam int CTRL_INSVC_BIT = 5;  // read: a source is in service

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Returns {valid, index} of the lowest set bit of v.
    function automatic logic [4:0] pick_lowest(input logic [NSRC-1:0] v);
        logic [4:0] res;
        res = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = {1'b1, i[3:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/chad_irqctl_if.sv
// chad_irqctl_if -- processor-side bus of the interrupt controller.
//   io_sel/io_addr/io_wr/io_rd/io_din/io_dout : register I/O port
//   irq/ivec/iack                              : interrupt request handshake
// Handshake: io_wr/io_rd are single-cycle strobes qualified by io_sel and
// sampled on the rising clock edge (writes) or decoded combinationally
// (reads). irq acts as "valid" for ivec: once irq is high, ivec is frozen
// until the cycle in which iack (the "ready") is seen high; the transfer
// completes on that edge and irq drops on the same edge.
interface chad_irqctl_if #(parameter int WIDTH = 18);
    logic             io_sel;
    logic [1:0]       io_addr;
    logic             io_wr;
    logic             io_rd;
    logic [WIDTH-1:0] io_din;
    logic [WIDTH-1:0] io_dout;
    logic             irq;
    logic [3:0]       ivec;
    logic             iack;

    modport master (
        output io_sel, io_addr, io_wr, io_rd, io_din, iack,
        input  io_dout, irq, ivec
    );

    modport slave (
        input  io_sel, io_addr, io_wr, io_rd, io_din, iack,
        output io_dout, irq, ivec
    );
endinterface

// File: rtl/chad_irq_sync.sv
// chad_irq_sync -- one interrupt source: two-flop synchronizer + rise detect.
//   clk, reset : system clock, async active-high reset
//   src        : raw source, asynchronous to clk
//   lvl        : synchronized level (two flops after src)
//   rise       : one-cycle pulse on a synchronized 0->1 transition
module chad_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic lvl,
    output logic rise
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= src;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/chad_irqctl.sv
// chad_irqctl -- 16-source fixed-priority interrupt controller.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   src       : 16 raw interrupt sources
//   bus       : chad_irqctl_if.slave (register I/O, irq/ivec/iack)
//   dbg_state : current controller FSM state
// Registers: 0 ENABLE, 1 PENDING (W1C), 2 MODE (1=edge), 3 CTRL
// (write: bit0 GIE, bit1 EOI; read: bit0 GIE, bits4:1 in-service vector,
// bit5 in-service flag).
module chad_irqctl
    import chad_irq_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    chad_irqctl_if.slave    bus,
    output irq_state_e      dbg_state
);
    logic [NSRC-1:0] sync_lvl;
    logic [NSRC-1:0] sync_rise;

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        chad_irq_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .src   (src[g]),
            .lvl   (sync_lvl[g]),
            .rise  (sync_rise[g])
        );
    end

    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] pend_q;
    logic            gie_q;
    logic [3:0]      insvc_vec_q;
    logic            irq_q;
    logic [3:0]      ivec_q;
    irq_state_e      state_q;
    irq_state_e      state_d;

    // Register write decode
    logic            wr_en;
    logic            wr_enable;
    logic            wr_pending;
    logic            wr_mode;
    logic            wr_ctrl;
    logic [NSRC-1:0] din16;
    logic            eoi;
    logic [NSRC-1:0] enable_d;
    logic            gie_d;

    assign wr_en      = bus.io_sel & bus.io_wr;
    assign wr_enable  = wr_en && (bus.io_addr == REG_ENABLE);
    assign wr_pending = wr_en && (bus.io_addr == REG_PENDING);
    assign wr_mode    = wr_en && (bus.io_addr == REG_MODE);
    assign wr_ctrl    = wr_en && (bus.io_addr == REG_CTRL);
    assign din16      = bus.io_din[NSRC-1:0];
    assign eoi        = wr_ctrl & bus.io_din[CTRL_EOI_BIT];
    assign enable_d   = wr_enable ? din16 : enable_q;
    assign gie_d      = wr_ctrl ? bus.io_din[CTRL_GIE_BIT] : gie_q;

    wire unused_din = &{1'b0, bus.io_din[WIDTH-1:NSRC]};

    // Edge-mode bits come from the sticky register; level-mode bits track
    // the synchronized source directly, so W1C and iack cannot touch them.
    logic [NSRC-1:0] pending;
    logic [4:0]      cand;

    assign pending = (mode_q & pend_q) | (~mode_q & sync_lvl);
    assign cand    = pick_lowest(pending & enable_q);

    logic [NSRC-1:0] ack_clr;

    always_comb begin
        state_d = state_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && cand[4]) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // iack wins over a same-cycle withdrawal. The withdrawal
                // test looks at the values being written this cycle so a
                // disable/GIE-off drops irq on the very edge it lands.
                if (bus.iack) begin
                    state_d = ST_SERVICE;
                    ack_clr[ivec_q] = mode_q[ivec_q];
                end else if (!gie_d || !enable_d[ivec_q] || !pending[ivec_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new synchronized edge overrides any clear in the same cycle.
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] pend_d;

    assign pend_clr = (wr_pending ? din16 : '0) | ack_clr;
    assign pend_d   = ((pend_q & ~pend_clr) | sync_rise) & mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pend_q      <= '0;
            gie_q       <= 1'b0;
            insvc_vec_q <= '0;
            irq_q       <= 1'b0;
            ivec_q      <= '0;
            state_q     <= ST_IDLE;
        end else begin
            enable_q <= enable_d;
            gie_q    <= gie_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            irq_q    <= (state_d == ST_REQ);
            if (wr_mode) begin
                mode_q <= din16;
            end
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                ivec_q <= cand[3:0];
            end
            if (state_q == ST_REQ && state_d == ST_SERVICE) begin
                insvc_vec_q <= ivec_q;
            end
        end
    end

    logic [WIDTH-1:0] rdata;

    always_comb begin
        rdata = '0;
        if (bus.io_sel && bus.io_rd) begin
            case (bus.io_addr)
                REG_ENABLE:  rdata[NSRC-1:0] = enable_q;
                REG_PENDING: rdata[NSRC-1:0] = pending;
                REG_MODE:    rdata[NSRC-1:0] = mode_q;
                default: begin
                    rdata[CTRL_GIE_BIT]       = gie_q;
                    rdata[CTRL_VEC_LSB +: 4]  = insvc_vec_q;
                    rdata[CTRL_INSVC_BIT]     = (state_q == ST_SERVICE);
                end
            endcase
        end
    end

    assign bus.io_dout = rdata;
    assign bus.irq     = irq_q;
    assign bus.ivec    = ivec_q;
    assign dbg_state   = state_q;
endmodule

// File: doc/chad_irqctl.md
CHAD_IRQCTL -- requirements
Module: chad_irqctl

Interface
REQ-001 Parameter WIDTH, default 18, I/O data width (16..32); NSRC fixed at 16 sources.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 src  input  16  raw interrupt sources, asynchronous to clk.
REQ-005 io_sel  input  1  controller selected by the I/O address decoder.
REQ-006 io_addr  input  2  register index.
REQ-007 io_wr  input  1  I/O write strobe.
REQ-008 io_rd  input  1  I/O read strobe.
REQ-009 io_din  input  WIDTH  write data (processor N).
REQ-010 io_dout  output  WIDTH  read data, combinational.
REQ-011 irq  output  1  interrupt request to processor, registered.
REQ-012 ivec  output  4  vector of the requested source, registered.
REQ-013 iack  input  1  processor acknowledge (already hold-gated).

Function
REQ-014 Registers SHALL be: 0 ENABLE (rw, bits 15:0), 1 PENDING (read; write-1-to-clear), 2 MODE (rw; 1=edge, 0=level per source), 3 CTRL (write bit0=GIE, bit1=EOI strobe; read bit0=GIE, bits4:1=in-service vector, bit5=in-service flag).
REQ-015 Unused register bits SHALL read 0; io_dout SHALL be 0 unless io_sel & io_rd.
REQ-016 Each src SHALL pass a two-flop synchronizer; edge mode sets PENDING on a synchronized 0->1 transition, 3 clk edges after src rises.
REQ-017 In level mode, PENDING[i] SHALL equal the synchronized level; write-1-to-clear and iack have no effect on it.
REQ-018 Same-cycle edge set and W1C on one bit: set wins.
REQ-019 Candidate = lowest index i with PENDING[i] & ENABLE[i]; index 0 is highest priority.
REQ-020 FSM states: IDLE, REQ, SERVICE.
REQ-021 IDLE->REQ when GIE & a candidate exists; irq=1 and ivec=candidate on the same edge.
REQ-022 In REQ, ivec SHALL stay frozen and irq SHALL stay high while iack=0.
REQ-023 REQ with iack=1 -> SERVICE: irq=0 next edge, in-service vector latched, PENDING[ivec] cleared if edge mode.
REQ-024 REQ with iack=0 and (frozen source no longer pending&enabled, or GIE=0) -> IDLE, irq=0; iack in the same cycle takes precedence.
REQ-025 SERVICE -> IDLE on CTRL write with bit1=1 (EOI); no irq is raised in SERVICE.
REQ-026 iack in IDLE or SERVICE SHALL be ignored.
REQ-027 A GIE=1 write with EOI in the same write SHALL both take effect; IDLE re-evaluation occurs the following cycle.

Reset
REQ-028 reset SHALL clear ENABLE, PENDING, MODE, GIE, the synchronizers, the in-service vector, irq=0 and ivec=0, and force the FSM to IDLE.
REQ-029 reset asserted in REQ or SERVICE SHALL abort the request with no acknowledge pending; irq is 0 while reset is high.

Structure
REQ-030 Package chad_irq_pkg SHALL hold the register index constants, CTRL bit positions and FSM state encoding.
REQ-031 Sub-module chad_irq_sync SHALL implement one source's two-flop synchronizer plus the rise detector, instantiated 16 times.

Verification
REQ-032 MODE=FFFF, ENABLE=0001, GIE=1, pulse src[0] -> irq=1 with ivec=0 within 4 cycles; iack -> irq=0, PENDING=0000, CTRL reads 0x21.
REQ-033 src[3] and src[9] rise in the same cycle, both enabled -> ivec=3; EOI -> next request ivec=9.
REQ-034 Level mode src[5] held high, acknowledged, EOI -> irq re-asserts with ivec=5; src[5] low, then EOI -> no irq.
REQ-035 In REQ for source 2, write ENABLE=0 with iack=0 -> irq=0 next cycle and state IDLE; repeat with iack=1 in the same cycle -> SERVICE.
REQ-036 W1C of PENDING bit 7 in the cycle a new src[7] edge arrives -> PENDING[7] reads 1.
REQ-037 Assert reset while in SERVICE -> all registers read 0, irq=0, ivec=0; after release a src edge with GIE=0 sets PENDING but not irq.
